pc_btb: RTL and testbench
=========================

PC_BTB -- requirements
Module: pc_btb

Interface
REQ-001 SHALL have parameter WIDTH, default 32: address/data width.
REQ-002 SHALL have parameter ENTRIES, default 16: BTB entry count, power of two, at least 2; IDX = log2(ENTRIES).
REQ-003 SHALL have parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port en, input, 1 bit: fetch enable; 0 = stall (hold PCF).
REQ-007 SHALL have port BranchE, input, 1 bit: a branch, jal or jalr is resolving in Execute this cycle.
REQ-008 SHALL have port TakenE, input, 1 bit: resolved direction.
REQ-009 SHALL have port PCE, input, WIDTH bits: PC of the resolving instruction.
REQ-010 SHALL have port TargetE, input, WIDTH bits: resolved target (PC+imm or jalr ALU result).
REQ-011 SHALL have port PredTakenE, input, 1 bit: the prediction made for PCE, carried down the pipeline.
REQ-012 SHALL have port PredTargetE, input, WIDTH bits: the predicted target carried down the pipeline.
REQ-013 SHALL have port PCF, output, WIDTH bits: current fetch PC.
REQ-014 SHALL have port PCPlus4F, output, WIDTH bits: PCF+4.
REQ-015 SHALL have port PredTakenF, output, 1 bit: prediction for PCF.
REQ-016 SHALL have port PredTargetF, output, WIDTH bits: predicted target for PCF.
REQ-017 SHALL have port MispredictE, output, 1 bit: redirect/flush request to the hazard unit.

Function
REQ-018 SHALL split PCF into index PCF[IDX+1:2] and tag PCF[WIDTH-1:IDX+2]; bits [1:0] are ignored.
REQ-019 SHALL assert PredTakenF combinationally iff the indexed entry is valid, its tag matches and its counter[1]=1; otherwise PredTargetF = PCPlus4F.
REQ-020 SHALL compute PCPlus4F = PCF+4 modulo 2^WIDTH (wraps at the top of the address space).
REQ-021 SHALL assert MispredictE = BranchE & ((TakenE != PredTakenE) | (TakenE & PredTakenE & TargetE != PredTargetE)).
REQ-022 SHALL select the next PC, in this priority order:
  - MispredictE: TakenE ? {TargetE[WIDTH-1:2],2'b00} : PCE+4
  - else en=0: hold PCF
  - else PredTakenF: PredTargetF
  - else: PCPlus4F
REQ-023 SHALL let a redirect override the stall (MispredictE loads PCF even when en=0).
REQ-024 SHALL, on BranchE with an index hit and tag match, increment (TakenE=1) or decrement (TakenE=0) the 2-bit counter, saturating at 2'b11 and 2'b00.
REQ-025 SHALL, on the same hit with TakenE=1, overwrite the stored target with the aligned TargetE.
REQ-026 SHALL, on BranchE with a miss and TakenE=1, allocate the entry (overwriting any occupant): valid=1, tag from PCE, aligned target, counter=2'b10.
REQ-027 SHALL not allocate on BranchE with a miss and TakenE=0.
REQ-028 SHALL perform all BTB writes on the rising edge; a same-cycle lookup of the same index sees the pre-update contents.
REQ-029 SHALL make no BTB update and no redirect while BranchE=0, regardless of the other E inputs.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force PCF=RESET_VECTOR, all valid bits=0 and all counters=2'b01.
REQ-031 SHALL therefore reset outputs to PCF=RESET_VECTOR, PCPlus4F=RESET_VECTOR+4, PredTakenF=0, PredTargetF=RESET_VECTOR+4, and MispredictE as a function of inputs only.
REQ-032 SHALL abort any in-flight update when reset asserts mid-operation; the first fetch after release is RESET_VECTOR.

Structure
REQ-033 SHALL place the 2'b00..2'b11 counter state constants and the BTB entry struct type (valid, tag, target, ctr) in the shared package riscv_pkg.
REQ-034 SHALL implement the BTB storage/update as one sub-module btb_table; PC register and next-PC mux stay in pc_btb.
REQ-035 SHALL use flop storage (no memory macros) for the BTB.

Verification
REQ-036 Reset then en=1 for 3 cycles, no branches -> PCF = 0x0, 0x4, 0x8, 0xC.
REQ-037 BranchE=1, PCE=0x10, TakenE=1, TargetE=0x40, PredTakenE=0 -> MispredictE=1; next PCF=0x40; a later fetch of 0x10 gives PredTakenF=1, PredTargetF=0x40, next PCF=0x40.
REQ-038 Same entry resolved not-taken twice -> counter 10->01->00; fetch of 0x10 gives PredTakenF=0; a redirect to 0x14 occurs on the first not-taken.
REQ-039 jalr with TargetE=0x103, mispredicted -> next PCF=0x100, stored target 0x100.
REQ-040 en=0 with MispredictE=1 -> PCF takes the redirect; en=0 without a branch -> PCF held.
REQ-041 PCF=0xFFFFFFFC, en=1, no prediction -> next PCF=0x0; asserting rst_n=0 mid-run -> PCF=RESET_VECTOR immediately and all predictions cleared.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared branch-prediction types: 2-bit counter states, BTB entry layout and
// the saturating counter step used by the BTB update path.
package riscv_pkg;

  // Widest address the BTB entry fields can hold; pc_btb WIDTH must not exceed it.
  localparam int XLEN = 32;

  // Two-bit direction counter states; bit 1 set means "predict taken".
  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken (reset state)
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken (allocation state)
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  // One BTB entry; tag is zero-extended, target is stored word-aligned.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
    logic [1:0]      ctr;
  } btb_entry_t;

  // Saturating increment on taken, saturating decrement on not taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
    if (taken) begin
      return (c == CTR_ST) ? CTR_ST : c + 2'b01;
    end
    return (c == CTR_SNT) ? CTR_SNT : c - 2'b01;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped branch target buffer held in flops. One combinational lookup
// port for fetch and one update port for the branch resolving in Execute.
// Updates commit on the rising edge, so a lookup in the same cycle sees the
// old contents.
module btb_table
  import riscv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-3:0] lk_word,
  output logic             lk_taken,
  output logic [WIDTH-1:0] lk_target,
  input  logic             upd_en,
  input  logic             upd_taken,
  input  logic [WIDTH-3:0] upd_word,
  input  logic [WIDTH-1:0] upd_target
);

  localparam int IDX = $clog2(ENTRIES);

  // Word addresses: low IDX bits select the entry, the rest form the tag.
  logic [IDX-1:0]  lk_idx;
  logic [XLEN-1:0] lk_tag;
  logic [IDX-1:0]  upd_idx;
  logic [XLEN-1:0] upd_tag;
  logic            upd_hit;
  btb_entry_t      lk_entry;
  btb_entry_t      upd_entry;

  btb_entry_t entries_q [ENTRIES];
  btb_entry_t entries_d [ENTRIES];

  assign lk_idx    = lk_word[IDX-1:0];
  assign lk_tag    = XLEN'(lk_word[WIDTH-3:IDX]);
  assign upd_idx   = upd_word[IDX-1:0];
  assign upd_tag   = XLEN'(upd_word[WIDTH-3:IDX]);
  assign lk_entry  = entries_q[lk_idx];
  assign upd_entry = entries_q[upd_idx];
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  // Fetch lookup: predict taken only on a valid tag match with counter bit 1 set.
  always_comb begin
    lk_taken  = lk_entry.valid && (lk_entry.tag == lk_tag) && lk_entry.ctr[1];
    lk_target = lk_entry.target[WIDTH-1:0];
  end

  // Next table contents: train on a hit, allocate on a taken miss, else keep.
  always_comb begin
    entries_d = entries_q;
    if (upd_en) begin
      if (upd_hit) begin
        entries_d[upd_idx].ctr = ctr_next(upd_entry.ctr, upd_taken);
        if (upd_taken) begin
          entries_d[upd_idx].target = XLEN'(upd_target);
        end
      end else if (upd_taken) begin
        entries_d[upd_idx] = '{valid: 1'b1, tag: upd_tag,
                               target: XLEN'(upd_target), ctr: CTR_WT};
      end
    end
  end

  // Table storage; reset invalidates every entry and parks counters at weakly-not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/pc_btb.sv
// Fetch PC register with BTB-based next-PC prediction. A mispredicted branch
// resolving in Execute redirects fetch (even through a stall) and trains the BTB.
module pc_btb
  import riscv_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               ENTRIES      = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             BranchE,
  input  logic             TakenE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] TargetE,
  input  logic             PredTakenE,
  input  logic [WIDTH-1:0] PredTargetE,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] PCPlus4F,
  output logic             PredTakenF,
  output logic [WIDTH-1:0] PredTargetF,
  output logic             MispredictE
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] tbl_target;
  logic [WIDTH-1:0] target_aligned;
  logic [WIDTH-1:0] redirect_pc;

  assign PCF            = pc_q;
  assign PCPlus4F       = pc_q + WIDTH'(4);
  assign target_aligned = {TargetE[WIDTH-1:2], 2'b00};
  assign PredTargetF    = PredTakenF ? tbl_target : PCPlus4F;

  // Wrong direction, or right "taken" with the wrong target, forces a redirect.
  assign MispredictE = BranchE & ((TakenE != PredTakenE) |
                                  (TakenE & PredTakenE & (TargetE != PredTargetE)));
  assign redirect_pc = TakenE ? target_aligned : PCE + WIDTH'(4);

  btb_table #(
    .WIDTH   (WIDTH),
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_word    (pc_q[WIDTH-1:2]),
    .lk_taken   (PredTakenF),
    .lk_target  (tbl_target),
    .upd_en     (BranchE),
    .upd_taken  (TakenE),
    .upd_word   (PCE[WIDTH-1:2]),
    .upd_target (target_aligned)
  );

  // Next-PC select: redirect beats stall, stall beats prediction.
  always_comb begin
    pc_d = PCPlus4F;
    if (MispredictE) begin
      pc_d = redirect_pc;
    end else if (!en) begin
      pc_d = pc_q;
    end else if (PredTakenF) begin
      pc_d = tbl_target;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_btb.sv
// Bench for pc_btb: directed scenarios plus a randomized run, all compared
// against a behavioural fetch/BTB model kept in plain arrays.
module tb_pc_btb;

  localparam int          WIDTH   = 32;
  localparam int          ENTRIES = 16;
  localparam int          IDX     = 4;
  localparam logic [31:0] RV      = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        BranchE, TakenE, PredTakenE;
  logic [31:0] PCE, TargetE, PredTargetE;
  logic [31:0] PCF, PCPlus4F, PredTargetF;
  logic        PredTakenF, MispredictE;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [31:0] m_pc;
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];

  pc_btb #(.WIDTH(WIDTH), .ENTRIES(ENTRIES), .RESET_VECTOR(RV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .BranchE(BranchE), .TakenE(TakenE),
    .PCE(PCE), .TargetE(TargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .PCF(PCF), .PCPlus4F(PCPlus4F), .PredTakenF(PredTakenF),
    .PredTargetF(PredTargetF), .MispredictE(MispredictE)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic m_reset();
    m_pc = RV;
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
  endtask

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic bit m_pred_taken(logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == (pc >> (IDX + 2))) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(logic [31:0] pc);
    return m_pred_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    return BranchE && ((TakenE != PredTakenE) ||
                       (TakenE && PredTakenE && (TargetE != PredTargetE)));
  endfunction

  task automatic set_e(input bit br, input bit tk, input logic [31:0] pce,
                       input logic [31:0] tgt, input bit pt, input logic [31:0] ptg);
    BranchE = br; TakenE = tk; PCE = pce; TargetE = tgt;
    PredTakenE = pt; PredTargetE = ptg;
  endtask

  // Advance one clock: model decides from pre-edge state, commits after the edge.
  task automatic tick();
    logic [31:0] npc;
    int          i;
    logic [31:0] t;
    bit          hit;
    bit          n_valid;
    logic [31:0] n_tag, n_tgt;
    int          n_ctr;
    if (m_mis())       npc = TakenE ? (TargetE & ~32'h3) : PCE + 32'd4;
    else if (!en)      npc = m_pc;
    else               npc = m_pred_target(m_pc);
    i = idx_of(PCE);
    t = PCE >> (IDX + 2);
    hit = m_valid[i] && (m_tag[i] == t);
    n_valid = m_valid[i]; n_tag = m_tag[i]; n_tgt = m_tgt[i]; n_ctr = m_ctr[i];
    if (BranchE) begin
      if (hit) begin
        n_ctr = TakenE ? ((n_ctr + 1 > 3) ? 3 : n_ctr + 1)
                       : ((n_ctr - 1 < 0) ? 0 : n_ctr - 1);
        if (TakenE) n_tgt = TargetE & ~32'h3;
      end else if (TakenE) begin
        n_valid = 1; n_tag = t; n_tgt = TargetE & ~32'h3; n_ctr = 2;
      end
    end
    @(posedge clk);
    #1;
    m_pc = npc;
    m_valid[i] = n_valid; m_tag[i] = n_tag; m_tgt[i] = n_tgt; m_ctr[i] = n_ctr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1;
    set_e(1, 1, 32'h0, 32'h0, 0, 32'h0);
    m_reset();
    #2;
    checks++; if (PCF !== RV) begin errors++; $display("FAIL rst_pcf got %h exp %h", PCF, RV); end
    checks++; if (PCPlus4F !== RV + 32'd4) begin errors++; $display("FAIL rst_pcplus4 got %h exp %h", PCPlus4F, RV + 32'd4); end
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL rst_predtaken got %b exp 0", PredTakenF); end
    checks++; if (PredTargetF !== RV + 32'd4) begin errors++; $display("FAIL rst_predtarget got %h exp %h", PredTargetF, RV + 32'd4); end
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL rst_mispredict_comb got %b exp 1", MispredictE); end
    set_e(0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL rst_mispredict_idle got %b exp 0", MispredictE); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC;
    for (int k = 0; k < 4; k++) begin
      checks++; if (PCF !== exp_pc[k]) begin errors++; $display("FAIL seq_pcf step %0d got %h exp %h", k, PCF, exp_pc[k]); end
      if (k < 3) tick();
    end
  endtask

  task automatic test_alloc();
    set_e(1, 1, 32'h10, 32'h40, 0, 32'h14);
    #1;
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got %b exp 1", MispredictE); end
    tick();
    checks++; if (PCF !== 32'h40) begin errors++; $display("FAIL alloc_redirect got %h exp 00000040", PCF); end
    set_e(1, 0, 32'hC, 32'h0, 1, 32'h30);
    tick();
    set_e(0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL alloc_refetch got %h exp 00000010", PCF); end
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL alloc_predtaken got %b exp 1", PredTakenF); end
    checks++; if (PredTargetF !== 32'h40) begin errors++; $display("FAIL alloc_predtarget got %h exp 00000040", PredTargetF); end
    tick();
    checks++; if (PCF !== 32'h40) begin errors++; $display("FAIL alloc_follow got %h exp 00000040", PCF); end
  endtask

  task automatic test_counter();
    set_e(1, 0, 32'h10, 32'h0, 1, 32'h40);
    #1;
    checks++; if (MispredictE !== 1'b1) begin errors++; $display("FAIL ctr_first_nt_mis got %b exp 1", MispredictE); end
    tick();
    checks++; if (PCF !== 32'h14) begin errors++; $display("FAIL ctr_redirect got %h exp 00000014", PCF); end
    set_e(1, 0, 32'h10, 32'h0, 0, 32'h14);
    #1;
    checks++; if (MispredictE !== 1'b0) begin errors++; $display("FAIL ctr_second_nt_mis got %b exp 0", MispredictE); end
    tick();
    set_e(1, 0, 32'hC, 32'h0, 1, 32'h30);
    tick();
    set_e(0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (PCF !== 32'h10) begin errors++; $display("FAIL ctr_refetch got %h exp 00000010", PCF); end
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL ctr_predtaken got %b exp 0", PredTakenF); end
    checks++; if (PredTargetF !== 32'h14) begin errors++; $display("FAIL ctr_predtarget got %h exp 00000014", PredTargetF); end
  endtask

  task automatic test_jalr();
    set_e(1, 1, 32'h80, 32'h103, 0, 32'h84);
    tick();
    checks++; if (PCF !== 32'h100) begin errors++; $display("FAIL jalr_redirect got %h exp 00000100", PCF); end
    set_e(1, 0, 32'h7C, 32'h0, 1, 32'h30);
    tick();
    set_e(0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL jalr_predtaken got %b exp 1", PredTakenF); end
    checks++; if (PredTargetF !== 32'h100) begin errors++; $display("FAIL jalr_stored_target got %h exp 00000100", PredTargetF); end
  endtask

  task automatic test_stall();
    en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (PCF !== 32'h80) begin errors++; $display("FAIL stall_hold step %0d got %h exp 00000080", k, PCF); end
    end
    set_e(1, 1, 32'h200, 32'h240, 0, 32'h0);
    tick();
    checks++; if (PCF !== 32'h240) begin errors++; $display("FAIL stall_redirect got %h exp 00000240", PCF); end
    set_e(0, 0, 32'h0, 32'h0, 0, 32'h0);
    en = 1'b1;
  endtask

  task automatic test_wrap_and_reset();
    set_e(1, 1, 32'h300, 32'hFFFFFFFC, 0, 32'h0);
    tick();
    set_e(0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (PCF !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pcf got %h exp fffffffc", PCF); end
    checks++; if (PCPlus4F !== 32'h0) begin errors++; $display("FAIL wrap_pcplus4 got %h exp 00000000", PCPlus4F); end
    tick();
    checks++; if (PCF !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 00000000", PCF); end
    set_e(1, 0, 32'h2FC, 32'h0, 1, 32'h0);
    tick();
    set_e(0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (PredTakenF !== 1'b1) begin errors++; $display("FAIL prereset_predtaken got %b exp 1", PredTakenF); end
    set_e(1, 1, 32'h340, 32'h500, 0, 32'h0);
    #2;
    rst_n = 1'b0;
    m_reset();
    #2;
    checks++; if (PCF !== RV) begin errors++; $display("FAIL midreset_pcf got %h exp %h", PCF, RV); end
    checks++; if (PredTargetF !== RV + 32'd4) begin errors++; $display("FAIL midreset_predtarget got %h exp %h", PredTargetF, RV + 32'd4); end
    set_e(0, 0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (PCF !== RV) begin errors++; $display("FAIL release_first_fetch got %h exp %h", PCF, RV); end
    set_e(1, 0, 32'h2FC, 32'h0, 1, 32'h0);
    tick();
    set_e(0, 0, 32'h0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (PCF !== 32'h300) begin errors++; $display("FAIL postreset_refetch got %h exp 00000300", PCF); end
    checks++; if (PredTakenF !== 1'b0) begin errors++; $display("FAIL postreset_cleared got %b exp 0", PredTakenF); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pce, tgt;
    bit          pt;
    for (int c = 0; c < 400; c++) begin
      pce = ($urandom_range(0, 3) == 0) ? m_pc : ($urandom_range(0, 255) & ~32'h3);
      tgt = $urandom_range(0, 255);
      pt  = ($urandom_range(0, 1) == 0) ? m_pred_taken(pce) : bit'($urandom_range(0, 1));
      set_e(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), pce, tgt, pt,
            ($urandom_range(0, 1) == 0) ? (tgt & ~32'h3) : 32'($urandom_range(0, 255)));
      en = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if (PCF !== m_pc) begin errors++; $display("FAIL rnd_pcf cycle %0d got %h exp %h", c, PCF, m_pc); end
      checks++; if (PCPlus4F !== m_pc + 32'd4) begin errors++; $display("FAIL rnd_pcplus4 cycle %0d got %h exp %h", c, PCPlus4F, m_pc + 32'd4); end
      checks++; if (PredTakenF !== m_pred_taken(m_pc)) begin errors++; $display("FAIL rnd_predtaken cycle %0d got %b exp %b", c, PredTakenF, m_pred_taken(m_pc)); end
      checks++; if (PredTargetF !== m_pred_target(m_pc)) begin errors++; $display("FAIL rnd_predtarget cycle %0d got %h exp %h", c, PredTargetF, m_pred_target(m_pc)); end
      checks++; if (MispredictE !== m_mis()) begin errors++; $display("FAIL rnd_mispredict cycle %0d got %b exp %b", c, MispredictE, m_mis()); end
      tick();
    end
    en = 1'b1;
    set_e(0, 0, 32'h0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_alloc();
    test_counter();
    test_jalr();
    test_stall();
    test_wrap_and_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
